// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field layout, rounding modes,
// integer saturation limits and the stage-1 register layout of the fcvt pipe.
package fpu_pkg;

   localparam int unsigned BIAS  = 127;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned SIG_W = 24;
   localparam int unsigned MAG_W = 33;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } rm_t;

   localparam logic [31:0] INT_MAX_S = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN_S = 32'h8000_0000;
   localparam logic [31:0] INT_MAX_U = 32'hFFFF_FFFF;

   // rm stays raw so the unassigned encodings 101-111 survive into rounding
   typedef struct packed {
      logic             s;
      logic [MAG_W-1:0] mag;
      logic             guard;
      logic             sticky;
      logic             nan;
      logic             inf;
      logic             ovf;
      logic             is_unsigned;
      logic [2:0]       rm;
   } s1_t;

endpackage

// File: rtl/fcvt_round.sv
// Combinational round-increment and saturation for the second stage of the
// float-to-integer converter.
module fcvt_round
   import fpu_pkg::*;
(
   input  s1_t         op,
   output logic [31:0] y,
   output logic        nv,
   output logic        nx
);

   logic        inc_s;
   logic        big_s;
   logic [32:0] r_s;

   assign r_s   = op.mag + {32'd0, inc_s};
   assign big_s = op.inf | op.ovf;

   // round-increment decision; reserved modes fall back to RNE
   always_comb begin
      inc_s = 1'b0;
      case (op.rm)
         RNE:     inc_s = op.guard & (op.sticky | op.mag[0]);
         RTZ:     inc_s = 1'b0;
         RDN:     inc_s = op.s & (op.guard | op.sticky);
         RUP:     inc_s = ~op.s & (op.guard | op.sticky);
         RMM:     inc_s = op.guard;
         default: inc_s = op.guard & (op.sticky | op.mag[0]);
      endcase
   end

   // saturation to the selected integer range and flag generation
   always_comb begin
      y  = 32'd0;
      nv = 1'b0;
      nx = op.guard | op.sticky;
      if (op.is_unsigned) begin
         if (op.nan | (~op.s & (big_s | r_s[32]))) begin
            y  = INT_MAX_U;
            nv = 1'b1;
            nx = 1'b0;
         end else if (op.s & (big_s | (r_s != 33'd0))) begin
            y  = 32'd0;
            nv = 1'b1;
            nx = 1'b0;
         end else begin
            y  = r_s[31:0];
         end
      end else begin
         if (op.nan | (~op.s & (big_s | r_s[32] | r_s[31]))) begin
            y  = INT_MAX_S;
            nv = 1'b1;
            nx = 1'b0;
         end else if (op.s & (big_s | (r_s > 33'h0_8000_0000))) begin
            y  = INT_MIN_S;
            nv = 1'b1;
            nx = 1'b0;
         end else begin
            y  = op.s ? (32'd0 - r_s[31:0]) : r_s[31:0];
         end
      end
   end

endmodule

// File: rtl/fcvt_w_s_pipe.sv
// Two-stage fcvt.w.s / fcvt.wu.s converter: S1 unpacks and aligns the operand,
// S2 holds the rounded, saturated integer and flags behind a valid/ready pair.
module fcvt_w_s_pipe
   import fpu_pkg::*;
#(
   parameter int unsigned BIAS = fpu_pkg::BIAS,
   parameter int unsigned XLEN = fpu_pkg::XLEN
)
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     x,
   input  logic            is_unsigned,
   input  logic [2:0]      rm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] y,
   output logic            nv,
   output logic            nx
);

   localparam logic [7:0] E_ONE  = 8'(BIAS);
   localparam logic [7:0] E_HALF = 8'(BIAS - 1);
   localparam logic [7:0] E_INT  = 8'(BIAS + 23);
   localparam logic [7:0] E_OVF  = 8'(BIAS + 32);

   logic        s1_valid_r;
   logic        s2_valid_r;
   logic        s2_load_s;
   logic        in_fire_s;
   s1_t         s1_r;
   s1_t         s1_d_s;
   logic [7:0]  exp_s;
   logic [22:0] man_s;
   logic [23:0] sig_s;
   logic [4:0]  sh_s;
   logic [31:0] y_d_s;
   logic        nv_d_s;
   logic        nx_d_s;

   assign s2_load_s = s1_valid_r & (~s2_valid_r | out_ready);
   assign in_ready  = ~s1_valid_r | s2_load_s;
   assign in_fire_s = in_valid & in_ready;
   assign out_valid = s2_valid_r;

   assign exp_s = x[30:23];
   assign man_s = x[22:0];
   assign sig_s = {1'b1, man_s};

   // unpack and align: integer magnitude plus guard/sticky for the dropped fraction
   always_comb begin
      s1_d_s             = '0;
      sh_s               = 5'd0;
      s1_d_s.s           = x[31];
      s1_d_s.is_unsigned = is_unsigned;
      s1_d_s.rm          = rm;
      if (exp_s == 8'd0) begin
         s1_d_s.mag = 33'd0;
      end else if (exp_s == 8'hFF) begin
         s1_d_s.nan = |man_s;
         s1_d_s.inf = ~|man_s;
      end else if (exp_s >= E_OVF) begin
         s1_d_s.ovf = 1'b1;
      end else if (exp_s >= E_INT) begin
         s1_d_s.mag = {9'd0, sig_s} << (exp_s - E_INT);
      end else if (exp_s >= E_ONE) begin
         sh_s          = 5'(E_INT - exp_s);
         s1_d_s.mag    = {9'd0, sig_s >> sh_s};
         s1_d_s.guard  = sig_s[sh_s - 5'd1];
         s1_d_s.sticky = |(sig_s & ((24'd1 << (sh_s - 5'd1)) - 24'd1));
      end else begin
         s1_d_s.guard  = (exp_s == E_HALF);
         s1_d_s.sticky = (exp_s < E_HALF) | (|man_s);
      end
   end

   fcvt_round u_round (
      .op (s1_r),
      .y  (y_d_s),
      .nv (nv_d_s),
      .nx (nx_d_s)
   );

   // stage 1 register: accepts a new operand whenever the input side fires
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_r <= 1'b0;
         s1_r       <= '0;
      end else if (in_fire_s) begin
         s1_valid_r <= 1'b1;
         s1_r       <= s1_d_s;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end else begin
         s1_valid_r <= s1_valid_r;
      end
   end

   // stage 2 register: result held stable until the consumer takes it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid_r <= 1'b0;
         y          <= '0;
         nv         <= 1'b0;
         nx         <= 1'b0;
      end else if (s2_load_s) begin
         s2_valid_r <= 1'b1;
         y          <= y_d_s;
         nv         <= nv_d_s;
         nx         <= nx_d_s;
      end else if (out_ready) begin
         s2_valid_r <= 1'b0;
      end else begin
         s2_valid_r <= s2_valid_r;
      end
   end

endmodule

// File: tb/tb_fcvt_w_s_pipe.sv
// Self-checking bench for fcvt_w_s_pipe: directed vector table, backpressure
// stream, random throughput run against an arithmetic model, and async reset.
module tb_fcvt_w_s_pipe;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] x;
   logic        is_unsigned;
   logic [2:0]  rm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        nv;
   logic        nx;

   int checks = 0;
   int errors = 0;

   fcvt_w_s_pipe dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .x           (x),
      .is_unsigned (is_unsigned),
      .rm          (rm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .y           (y),
      .nv          (nv),
      .nx          (nx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic        uns;
      logic [2:0]  rm;
      logic [31:0] y;
      logic        nv;
      logic        nx;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [31:0] xv, input logic uv, input logic [2:0] rv,
                               input logic [31:0] yv, input logic nvv, input logic nxv);
      vec_t v;
      v.x = xv; v.uns = uv; v.rm = rv; v.y = yv; v.nv = nvv; v.nx = nxv;
      tbl.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Exact value = sig * 2^(e-150); split into integer quotient and remainder,
   // round by comparing the remainder with one half, then clamp to the range.
   function automatic void model(input logic [31:0] xv, input logic uv, input logic [2:0] rv,
                                 output logic [31:0] ye, output logic nve, output logic nxe);
      int     e;
      int     sh;
      longint sig, q, rem, half, mag, val;
      bit     s, up;
      s   = xv[31];
      e   = int'(xv[30:23]);
      sig = longint'({1'b1, xv[22:0]});
      ye  = 32'd0; nve = 1'b0; nxe = 1'b0;
      if (e == 0) return;
      if (e == 255 && xv[22:0] != 23'd0) begin
         ye  = uv ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
         nve = 1'b1;
         return;
      end
      rem = 0; half = 1;
      if (e == 255 || e >= 190) q = 64'sd1 << 40;
      else if (e >= 150) q = sig << (e - 150);
      else begin
         sh = 150 - e;
         if (sh > 40) sh = 40;
         q    = sig >> sh;
         rem  = sig - (q << sh);
         half = 64'sd1 << (sh - 1);
      end
      case (rv)
         3'd1:    up = 1'b0;
         3'd2:    up = s && rem != 0;
         3'd3:    up = !s && rem != 0;
         3'd4:    up = rem >= half && rem != 0;
         default: up = (rem > half) || (rem == half && rem != 0 && q[0]);
      endcase
      mag = q + longint'(up);
      val = s ? -mag : mag;
      if (uv) begin
         if (val > 64'sd4294967295) begin ye = 32'hFFFF_FFFF; nve = 1'b1; end
         else if (val < 0) begin ye = 32'd0; nve = 1'b1; end
         else begin ye = val[31:0]; nxe = (rem != 0); end
      end else begin
         if (val > 64'sd2147483647) begin ye = 32'h7FFF_FFFF; nve = 1'b1; end
         else if (val < -64'sd2147483648) begin ye = 32'h8000_0000; nve = 1'b1; end
         else begin ye = val[31:0]; nxe = (rem != 0); end
      end
   endfunction

   task automatic run_one(input logic [31:0] xv, input logic uv, input logic [2:0] rv,
                          output logic [31:0] yo, output logic nvo, output logic nxo,
                          output bit got);
      x = xv; is_unsigned = uv; rm = rv; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      got = 1'b0; yo = 32'd0; nvo = 1'b0; nxo = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid && !got) begin
            got = 1'b1; yo = y; nvo = nv; nxo = nx;
         end
         @(posedge clk); #1;
         if (got) break;
      end
   endtask

   logic [31:0] exp_y [100];
   logic        exp_nv[100];
   logic        exp_nx[100];
   logic [31:0] vals  [8];

   initial begin
      logic [31:0] ry;
      logic        rnv, rnx;
      bit          got;
      int          sent, rcvd, occ;
      bit          prev_stall;
      logic [31:0] prev_y;

      // ---------------- reset state ----------------
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = 32'd0; is_unsigned = 1'b0; rm = 3'd0;
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_y", y, 32'd0);
      check("rst_nv", nv, 1'b0);
      check("rst_nx", nx, 1'b0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1'b1);

      // ---------------- directed vector table ----------------
      add(32'h3FC00000, 1'b0, 3'd0, 32'd2, 1'b0, 1'b1);
      add(32'h3FC00000, 1'b0, 3'd1, 32'd1, 1'b0, 1'b1);
      add(32'h3FC00000, 1'b0, 3'd2, 32'd1, 1'b0, 1'b1);
      add(32'h3FC00000, 1'b0, 3'd3, 32'd2, 1'b0, 1'b1);
      add(32'h3FC00000, 1'b0, 3'd4, 32'd2, 1'b0, 1'b1);
      add(32'h40200000, 1'b0, 3'd0, 32'd2, 1'b0, 1'b1);
      add(32'h40200000, 1'b0, 3'd1, 32'd2, 1'b0, 1'b1);
      add(32'h40200000, 1'b0, 3'd2, 32'd2, 1'b0, 1'b1);
      add(32'h40200000, 1'b0, 3'd3, 32'd3, 1'b0, 1'b1);
      add(32'h40200000, 1'b0, 3'd4, 32'd3, 1'b0, 1'b1);
      add(32'hC0200000, 1'b0, 3'd0, 32'hFFFFFFFE, 1'b0, 1'b1);
      add(32'hC0200000, 1'b0, 3'd1, 32'hFFFFFFFE, 1'b0, 1'b1);
      add(32'hC0200000, 1'b0, 3'd2, 32'hFFFFFFFD, 1'b0, 1'b1);
      add(32'hC0200000, 1'b0, 3'd3, 32'hFFFFFFFE, 1'b0, 1'b1);
      add(32'hC0200000, 1'b0, 3'd4, 32'hFFFFFFFD, 1'b0, 1'b1);
      add(32'h40200000, 1'b0, 3'd6, 32'd2, 1'b0, 1'b1);
      add(32'h40600000, 1'b0, 3'd0, 32'd4, 1'b0, 1'b1);
      add(32'h4F000000, 1'b0, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
      add(32'hCF000000, 1'b0, 3'd0, 32'h80000000, 1'b0, 1'b0);
      add(32'h7FC00000, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
      add(32'hFF800000, 1'b1, 3'd0, 32'd0, 1'b1, 1'b0);
      add(32'h4F800000, 1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
      add(32'h4F7FFFFF, 1'b1, 3'd0, 32'hFFFFFF00, 1'b0, 1'b0);
      add(32'hBECCCCCD, 1'b1, 3'd0, 32'd0, 1'b0, 1'b1);
      add(32'hBECCCCCD, 1'b1, 3'd2, 32'd0, 1'b1, 1'b0);
      add(32'hBECCCCCD, 1'b0, 3'd2, 32'hFFFFFFFF, 1'b0, 1'b1);
      add(32'h00400000, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      add(32'h80000000, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0);
      add(32'h80000000, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0);

      foreach (tbl[i]) begin
         run_one(tbl[i].x, tbl[i].uns, tbl[i].rm, ry, rnv, rnx, got);
         check($sformatf("vec%0d_timeout", i), got, 1'b1);
         check($sformatf("vec%0d_y x=%h", i, tbl[i].x), ry, tbl[i].y);
         check($sformatf("vec%0d_nv", i), rnv, tbl[i].nv);
         check($sformatf("vec%0d_nx", i), rnx, tbl[i].nx);
      end

      // ---------------- backpressure stream 1.0 .. 8.0 ----------------
      vals[0] = 32'h3F800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000; vals[3] = 32'h40800000;
      vals[4] = 32'h40A00000; vals[5] = 32'h40C00000; vals[6] = 32'h40E00000; vals[7] = 32'h41000000;
      sent = 0; rcvd = 0; occ = 0; prev_stall = 1'b0; prev_y = 32'd0;
      is_unsigned = 1'b0; rm = 3'd1;
      for (int c = 0; c < 80 && rcvd < 8; c++) begin
         out_ready = (c % 3 == 0);
         in_valid  = (sent < 8);
         if (sent < 8) x = vals[sent];
         else x = 32'd0;
         @(negedge clk);
         if (prev_stall) begin
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_y", y, prev_y);
         end
         check("bp_in_ready", in_ready, logic'(!(occ == 2 && !out_ready)));
         if (out_valid && out_ready) begin
            check("bp_order", y, 32'(rcvd + 1));
            rcvd++;
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
         if (in_valid && in_ready) sent++;
         occ = sent - rcvd;
         @(posedge clk); #1;
      end
      check("bp_count", rcvd, 8);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("bp_no_dup", out_valid, 1'b0);
         @(posedge clk); #1;
      end

      // ---------------- random throughput vs model ----------------
      out_ready = 1'b1;
      for (int t = 0; t < 102; t++) begin
         if (t < 100) begin
            logic [7:0] ev;
            int cat;
            cat = $urandom_range(0, 9);
            if (cat == 0) ev = 8'd0;
            else if (cat == 1) ev = 8'hFF;
            else if (cat == 2) ev = 8'($urandom_range(0, 255));
            else ev = 8'($urandom_range(110, 165));
            x = {1'($urandom), ev, 23'($urandom)};
            is_unsigned = 1'($urandom);
            rm = 3'($urandom_range(0, 7));
            in_valid = 1'b1;
            model(x, is_unsigned, rm, exp_y[t], exp_nv[t], exp_nx[t]);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (t < 100) check("tp_in_ready", in_ready, 1'b1);
         if (t >= 2) begin
            check($sformatf("tp%0d_valid", t - 2), out_valid, 1'b1);
            check($sformatf("tp%0d_y", t - 2), y, exp_y[t - 2]);
            check($sformatf("tp%0d_nv", t - 2), nv, exp_nv[t - 2]);
            check($sformatf("tp%0d_nx", t - 2), nx, exp_nx[t - 2]);
         end else begin
            check("tp_latency", out_valid, 1'b0);
         end
         @(posedge clk); #1;
      end

      // ---------------- asynchronous reset with both stages full ----------------
      out_ready = 1'b0; is_unsigned = 1'b0; rm = 3'd0;
      x = 32'h40200000; in_valid = 1'b1;
      @(posedge clk); #1;
      x = 32'h40600000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #1;
      check("mr_full_valid", out_valid, 1'b1);
      check("mr_full_y", y, 32'd2);
      check("mr_full_nx", nx, 1'b1);
      check("mr_full_in_ready", in_ready, 1'b0);
      #1 rstn = 1'b0;
      #1;
      check("mr_out_valid", out_valid, 1'b0);
      check("mr_y", y, 32'd0);
      check("mr_nv", nv, 1'b0);
      check("mr_nx", nx, 1'b0);
      @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      check("mr_in_ready", in_ready, 1'b1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("mr_no_stale", out_valid, 1'b0);
         @(posedge clk); #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog: never hang
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
